// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the parametrised UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK_WAIT
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_LO      = 4'd7;
    localparam logic [3:0] MID_HI      = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // Two-out-of-three vote used for every bit decision
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every div+1 clocks while enabled
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // Divisor counter: restarts on reload, parks at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload || !en) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - 16x oversampling UART receiver, optional break detect via UART_RX_BREAK_DETECT_EN
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              DataTx,
    input  logic [DIV_W-1:0]  BaudDiv,
    input  logic [1:0]        ParityType,
    input  logic              StopBits,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    input  logic              Ready,
    output logic              ParityError,
    output logic              FrameError,
    output logic              Overrun,
    output logic              Break,
    output logic              Busy
);

    rx_state_t         state;
    logic              rx_meta, rx_sync, rx_prev;
    logic              start_det, tick, bit_val;
    logic [3:0]        sample_cnt, bit_cnt;
    logic              s7, s8;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bit, stop1_ok;
    logic [DIV_W-1:0]  div_l;
    logic [1:0]        par_l;
    logic              two_stop_l;
    logic              par_en, final_stop, stop_ok, frame_perr;
    logic              done;
    logic [DATA_W-1:0] frm_data;
    logic              frm_perr, frm_ferr;
`ifdef UART_RX_BREAK_DETECT_EN
    logic              frame_brk, frm_brk, brk_q;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= DataTx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_det  = (state == IDLE) && rx_prev && !rx_sync;
    assign Busy       = (state != IDLE);
    assign bit_val    = maj3(s7, s8, rx_sync);
    assign par_en     = (par_l == PAR_ODD) || (par_l == PAR_EVEN);
    assign final_stop = (sample_cnt == MID_HI) &&
                        ((state == STOP2) || ((state == STOP1) && !two_stop_l));
    assign stop_ok    = (state == STOP2) ? (stop1_ok & bit_val) : bit_val;
    assign frame_perr = par_en && ((^shift_reg ^ par_bit) != (par_l == PAR_ODD));
`ifdef UART_RX_BREAK_DETECT_EN
    assign frame_brk  = (shift_reg == '0) && !(par_en && par_bit) &&
                        ((state == STOP2) ? (!stop1_ok && !bit_val) : !bit_val);
`endif

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (Clock),
        .rst    (Reset),
        .en     (Busy),
        .reload (start_det),
        .div    (div_l),
        .tick   (tick)
    );

    // Receive FSM: latch config at start, vote at mid-bit, advance at bit boundary
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            stop1_ok   <= 1'b0;
            div_l      <= '0;
            par_l      <= PAR_NONE;
            two_stop_l <= 1'b0;
            done       <= 1'b0;
            frm_data   <= '0;
            frm_perr   <= 1'b0;
            frm_ferr   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            frm_brk    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start_det) begin
                state      <= START;
                sample_cnt <= '0;
                bit_cnt    <= '0;
                div_l      <= BaudDiv;
                par_l      <= ParityType;
                two_stop_l <= StopBits;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            else if (state == BREAK_WAIT) begin
                if (tick) begin
                    if (!rx_sync) begin
                        sample_cnt <= '0;
                    end else if (sample_cnt == LAST_SAMPLE) begin
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
            end
`endif
            else if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
                if (sample_cnt == MID_LO)         s7 <= rx_sync;
                if (sample_cnt == MID_LO + 4'd1)  s8 <= rx_sync;
                if (sample_cnt == MID_HI) begin
                    case (state)
                        START: begin
                            if (bit_val) begin
                                state      <= IDLE;
                                sample_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                        PARITY:  par_bit  <= bit_val;
                        STOP1:   stop1_ok <= bit_val;
                        default: ;
                    endcase
                end
                if (final_stop) begin
                    done       <= 1'b1;
                    frm_data   <= shift_reg;
                    frm_perr   <= frame_perr;
                    frm_ferr   <= !stop_ok;
                    sample_cnt <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                    frm_brk    <= frame_brk;
                    state      <= frame_brk ? BREAK_WAIT : IDLE;
`else
                    state      <= IDLE;
`endif
                end
                if (sample_cnt == LAST_SAMPLE) begin
                    case (state)
                        START:   state <= DATA;
                        DATA:    if (bit_cnt == 4'(DATA_W)) state <= par_en ? PARITY : STOP1;
                        PARITY:  state <= STOP1;
                        STOP1:   state <= STOP2;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Holding register: load on completion unless a word is still waiting
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Data        <= '0;
            Valid       <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
            Overrun     <= 1'b0;
        end else if (done) begin
            if (!Valid || Ready) begin
                Data        <= frm_data;
                ParityError <= frm_perr;
                FrameError  <= frm_ferr;
                Valid       <= 1'b1;
                if (Valid) Overrun <= 1'b0;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Valid && Ready) begin
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // Break flag follows the frame load and drops on an accepted handshake
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            brk_q <= 1'b0;
        end else if (done && (!Valid || Ready)) begin
            brk_q <= frm_brk;
        end else if (Valid && Ready) begin
            brk_q <= 1'b0;
        end
    end
    assign Break = brk_q;
`else
    assign Break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param
module tb_uart_rx_param;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx8 = 1'b1, tx7 = 1'b1;
    logic [15:0] div8 = 16'd3, div7 = 16'd3;
    logic [1:0]  pt8 = 2'b00, pt7 = 2'b00;
    logic        sb8 = 1'b0, sb7 = 1'b0;
    logic        rdy8 = 1'b1, rdy7 = 1'b1;
    logic [7:0]  data8;
    logic [6:0]  data7;
    logic        valid8, perr8, ferr8, ovr8, brk8, busy8;
    logic        valid7, perr7, ferr7, ovr7, brk7, busy7;

    int checks = 0;
    int failures = 0;

    logic [10:0] q8[$];
    logic [10:0] q7[$];
    int          vcnt8 = 0;
    logic        pv8 = 1'b0, pr8 = 1'b0, pv7 = 1'b0, pr7 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_W(8), .DIV_W(16)) dut8 (
        .Clock(clk), .Reset(rst), .DataTx(tx8), .BaudDiv(div8), .ParityType(pt8),
        .StopBits(sb8), .Data(data8), .Valid(valid8), .Ready(rdy8),
        .ParityError(perr8), .FrameError(ferr8), .Overrun(ovr8), .Break(brk8), .Busy(busy8)
    );

    uart_rx_param #(.DATA_W(7), .DIV_W(16)) dut7 (
        .Clock(clk), .Reset(rst), .DataTx(tx7), .BaudDiv(div7), .ParityType(pt7),
        .StopBits(sb7), .Data(data7), .Valid(valid7), .Ready(rdy7),
        .ParityError(perr7), .FrameError(ferr7), .Overrun(ovr7), .Break(brk7), .Busy(busy7)
    );

    // Word monitor: a new word is presented whenever Valid is high and the
    // previous cycle did not hold an unaccepted word
    always @(negedge clk) begin
        if (valid8) vcnt8++;
        if (valid8 && !(pv8 && !pr8)) q8.push_back({1'b0, data8, perr8, ferr8});
        if (valid7 && !(pv7 && !pr7)) q7.push_back({2'b00, data7, perr7, ferr7});
        pv8 = valid8; pr8 = rdy8;
        pv7 = valid7; pr7 = rdy7;
    end

    // Reference model: required parity bit for a clean frame
    function automatic logic good_parity(input logic [8:0] word, input int dw, input logic [1:0] pt);
        logic [8:0] mask;
        int ones;
        mask = 9'((1 << dw) - 1);
        ones = $countones(word & mask);
        if (pt == PAR_ODD)  return (ones % 2) == 0;
        if (pt == PAR_EVEN) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    // Reference model: parity error from total count of ones
    function automatic logic model_perr(input logic [8:0] word, input int dw, input logic [1:0] pt, input logic pbit);
        logic [8:0] mask;
        int total;
        mask = 9'((1 << dw) - 1);
        total = $countones(word & mask) + int'(pbit);
        if (pt == PAR_ODD)  return (total % 2) == 0;
        if (pt == PAR_EVEN) return (total % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] build_frame(input logic [8:0] word, input int dw, input logic [1:0] pt,
                                                input logic pbit, input logic s1, input logic s2,
                                                input logic two, output int n);
        logic [15:0] f;
        f = '0;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < dw; i++) begin f[n] = word[i]; n++; end
        if (pt == PAR_ODD || pt == PAR_EVEN) begin f[n] = pbit; n++; end
        f[n] = s1; n++;
        if (two) begin f[n] = s2; n++; end
        return f;
    endfunction

    task automatic drive_bits(input logic [15:0] bits, input int n, input int bclk, input bit to7);
        for (int i = 0; i < n; i++) begin
            if (to7) tx7 = bits[i]; else tx8 = bits[i];
            repeat (bclk) @(negedge clk);
        end
        if (to7) tx7 = 1'b1; else tx8 = 1'b1;
    endtask

    task automatic send8(input logic [8:0] word, input logic pbit, input logic s1, input logic s2);
        logic [15:0] f;
        int n;
        f = build_frame(word, 8, pt8, pbit, s1, s2, sb8, n);
        drive_bits(f, n, (int'(div8) + 1) * OVERSAMPLE, 1'b0);
    endtask

    task automatic send7(input logic [8:0] word, input logic pbit, input logic s1, input logic s2);
        logic [15:0] f;
        int n;
        f = build_frame(word, 7, pt7, pbit, s1, s2, sb7, n);
        drive_bits(f, n, (int'(div7) + 1) * OVERSAMPLE, 1'b1);
    endtask

    task automatic idle8(input int bits);
        repeat (bits * (int'(div8) + 1) * OVERSAMPLE) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({data8, valid8, perr8, ferr8, ovr8, brk8, busy8} !== 14'h0) begin
            failures++; $display("FAIL reset_dut8 got=%h exp=0", {data8, valid8, perr8, ferr8, ovr8, brk8, busy8});
        end
        checks++;
        if ({data7, valid7, perr7, ferr7, ovr7, brk7, busy7} !== 13'h0) begin
            failures++; $display("FAIL reset_dut7 got=%h exp=0", {data7, valid7, perr7, ferr7, ovr7, brk7, busy7});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [10:0] e;
        pt8 = PAR_NONE; sb8 = 1'b0; div8 = 16'd3; rdy8 = 1'b1;
        q8.delete(); vcnt8 = 0;
        send8(9'h0A5, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (q8.size() !== 1) begin failures++; $display("FAIL 8n1_count got=%0d exp=1", q8.size()); end
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h0A5, 2'b00}) begin failures++; $display("FAIL 8n1_word got=%h exp=%h", e, {9'h0A5, 2'b00}); end
        checks++;
        if (vcnt8 !== 1) begin failures++; $display("FAIL 8n1_valid_cycles got=%0d exp=1", vcnt8); end
        idle8(1);
    endtask

    task automatic test_even_parity();
        logic [10:0] e;
        pt8 = PAR_EVEN; sb8 = 1'b0; q8.delete();
        send8(9'h03C, good_parity(9'h03C, 8, PAR_EVEN), 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h03C, 2'b00}) begin failures++; $display("FAIL even_ok got=%h exp=%h", e, {9'h03C, 2'b00}); end
        idle8(1);
        send8(9'h03C, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h03C, 2'b10}) begin failures++; $display("FAIL even_bad got=%h exp=%h", e, {9'h03C, 2'b10}); end
        idle8(1);
    endtask

    task automatic test_8n2_frame();
        logic [10:0] e;
        pt8 = PAR_NONE; sb8 = 1'b1; q8.delete();
        send8(9'h05A, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h05A, 2'b01}) begin failures++; $display("FAIL 8n2_stop2_low got=%h exp=%h", e, {9'h05A, 2'b01}); end
        send8(9'h011, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h011, 2'b00}) begin failures++; $display("FAIL 8n2_next got=%h exp=%h", e, {9'h011, 2'b00}); end
        idle8(1);
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        pt8 = PAR_NONE; sb8 = 1'b0; q8.delete();
        send8(9'h0C3, 1'b0, 1'b1, 1'b1);
        send8(9'h03C, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (q8.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", q8.size()); end
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h0C3, 2'b00}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", e, {9'h0C3, 2'b00}); end
        e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h03C, 2'b00}) begin failures++; $display("FAIL b2b_second got=%h exp=%h", e, {9'h03C, 2'b00}); end
        idle8(1);
    endtask

    task automatic test_overrun();
        pt8 = PAR_NONE; sb8 = 1'b0; q8.delete();
        @(posedge clk); #2 rdy8 = 1'b0;
        send8(9'h001, 1'b0, 1'b1, 1'b1);
        idle8(1);
        checks++;
        if ({valid8, data8, ovr8} !== {1'b1, 8'h01, 1'b0}) begin
            failures++; $display("FAIL ovr_first got=%h exp=%h", {valid8, data8, ovr8}, {1'b1, 8'h01, 1'b0});
        end
        send8(9'h002, 1'b0, 1'b1, 1'b1);
        idle8(1);
        checks++;
        if ({valid8, data8, ovr8} !== {1'b1, 8'h01, 1'b1}) begin
            failures++; $display("FAIL ovr_held got=%h exp=%h", {valid8, data8, ovr8}, {1'b1, 8'h01, 1'b1});
        end
        checks++;
        if (q8.size() !== 1) begin failures++; $display("FAIL ovr_words got=%0d exp=1", q8.size()); end
        @(posedge clk); #2 rdy8 = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({valid8, ovr8} !== 2'b00) begin failures++; $display("FAIL ovr_accept got=%b exp=00", {valid8, ovr8}); end
        q8.delete();
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 1'b0;
        div8 = 16'd3; q8.delete();
        @(negedge clk); tx8 = 1'b0;
        repeat (16) @(negedge clk);
        tx8 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy8) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse got=%b exp=1", seen); end
        checks++;
        if (busy8 !== 1'b0) begin failures++; $display("FAIL glitch_busy_idle got=%b exp=0", busy8); end
        checks++;
        if (q8.size() !== 0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", q8.size()); end
    endtask

    task automatic test_random();
        logic [8:0]  w;
        logic        pbit, s1, s2, exp_pe, exp_fe;
        logic [10:0] e;
        rdy8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            w    = 9'($urandom_range(0, 255));
            pt8  = 2'($urandom_range(0, 3));
            sb8  = 1'($urandom_range(0, 1));
            div8 = 16'($urandom_range(1, 3));
            pbit = good_parity(w, 8, pt8);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            exp_pe = model_perr(w, 8, pt8, pbit);
            exp_fe = !s1 || (sb8 && !s2);
            q8.delete();
            send8(w, pbit, s1, s2);
            repeat (8) @(negedge clk);
            e = (q8.size() > 0) ? q8.pop_front() : 11'h7FF;
            checks++;
            if (e !== {w, exp_pe, exp_fe}) begin
                failures++;
                $display("FAIL random_%0d got=%h exp=%h (pt=%b sb=%b)", k, e, {w, exp_pe, exp_fe}, pt8, sb8);
            end
            idle8(1);
        end
    endtask

    task automatic test_7bit_odd();
        logic [10:0] e;
        pt7 = PAR_ODD; sb7 = 1'b0; div7 = 16'd3; q7.delete();
        send7(9'h07F, good_parity(9'h07F, 7, PAR_ODD), 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        e = (q7.size() > 0) ? q7.pop_front() : 11'h7FF;
        checks++;
        if (e !== {9'h07F, 2'b00}) begin failures++; $display("FAIL w7_odd got=%h exp=%h", e, {9'h07F, 2'b00}); end
        repeat (64) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int bc;
        bc = (int'(div7) + 1) * OVERSAMPLE;
        q7.delete();
        @(negedge clk); tx7 = 1'b0;
        repeat (bc) @(negedge clk); tx7 = 1'b1;
        repeat (bc) @(negedge clk); tx7 = 1'b0;
        repeat (bc) @(negedge clk); tx7 = 1'b1;
        repeat (bc / 2) @(negedge clk);
        checks++;
        if (busy7 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy7); end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy7, valid7} !== 2'b00) begin failures++; $display("FAIL midrst_during got=%b exp=00", {busy7, valid7}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * bc) @(negedge clk);
        checks++;
        if (q7.size() !== 0) begin failures++; $display("FAIL midrst_no_word got=%0d exp=0", q7.size()); end
        checks++;
        if ({busy7, valid7} !== 2'b00) begin failures++; $display("FAIL midrst_after got=%b exp=00", {busy7, valid7}); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_even_parity();
        test_8n2_frame();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_random();
        test_7bit_odd();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
